// File: rtl/branch_target_buffer_pkg.sv
// Shared definitions for the branch target buffer.
//
// Contents:
//   - 2-bit direction counter encodings.
//   - Default entry count and helpers that derive index and tag widths from it.
//
// Optional feature macro used elsewhere in this slice: BRANCH_TARGET_BUFFER_STATS_EN.

package branch_target_buffer_pkg;

    // Direction counter encodings. Bit 1 is the predicted direction.
    localparam logic [1:0] STRONG_NT = 2'b00;
    localparam logic [1:0] WEAK_NT   = 2'b01;
    localparam logic [1:0] WEAK_T    = 2'b10;
    localparam logic [1:0] STRONG_T  = 2'b11;

    localparam int unsigned BTB_ENTRIES = 16;

    // Index width: log2 of the entry count.
    function automatic int unsigned btb_idx_w(input int unsigned entries);
        return $clog2(entries);
    endfunction

    // Tag width: the word-aligned PC (30 bits) minus the index bits.
    function automatic int unsigned btb_tag_w(input int unsigned idx_w);
        return 30 - idx_w;
    endfunction

endpackage

// File: rtl/sat_counter_2bit.sv
// Combinational next-state of a 2-bit saturating direction counter.
//
// Ports:
//   ctr_i          current counter value
//   taken_i        resolved direction (1 = count up, 0 = count down)
//   force_strong_i jump resolution; forces strongly-taken regardless of ctr_i
//   ctr_o          next counter value, saturating at STRONG_NT and STRONG_T

module sat_counter_2bit
    import branch_target_buffer_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    input  logic       force_strong_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (force_strong_i) begin
            ctr_o = STRONG_T;
        end else if (taken_i) begin
            if (ctr_i != STRONG_T) begin
                ctr_o = ctr_i + 2'd1;
            end
        end else begin
            if (ctr_i != STRONG_NT) begin
                ctr_o = ctr_i - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
//
// Lookup is combinational: the PC stage presents PC_LOOKUP and receives
// PREDICT_TAKEN / PREDICT_TARGET in the same cycle. Resolutions from the
// execution stage train the table and become visible on the following cycle;
// a lookup to the entry being updated sees the pre-update contents.
//
// Ports:
//   CLK              clock, all state changes on the rising edge
//   RST              synchronous active-high reset; clears all valid bits
//   PC_LOOKUP        current fetch PC (bits [1:0] ignored)
//   PREDICT_TAKEN    hit on a valid entry whose counter predicts taken
//   PREDICT_TARGET   stored target of the hit entry, 0 when not predicting taken
//   UPDATE_VALID     resolution strobe, one update per cycle
//   UPDATE_PC        PC of the resolved branch/jump
//   UPDATE_TAKEN     resolved direction
//   UPDATE_TARGET    resolved target, stored as given (all 32 bits)
//   UPDATE_IS_JUMP   JAL/JALR; writes a strongly-taken entry unconditionally
//   STAT_UPDATES     (BRANCH_TARGET_BUFFER_STATS_EN only) accepted updates
//   STAT_MISPREDICTS (BRANCH_TARGET_BUFFER_STATS_EN only) mispredicted updates
//
// Optional feature macro: BRANCH_TARGET_BUFFER_STATS_EN adds the two saturating
// statistics counters. Without it the table behaves identically.

module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int unsigned ENTRIES = BTB_ENTRIES,
    parameter int unsigned IDX_W   = btb_idx_w(ENTRIES),
    parameter int unsigned TAG_W   = btb_tag_w(IDX_W)
) (
    input  logic        CLK,
    input  logic        RST,

    input  logic [31:0] PC_LOOKUP,
    output logic        PREDICT_TAKEN,
    output logic [31:0] PREDICT_TARGET,

    input  logic        UPDATE_VALID,
    input  logic [31:0] UPDATE_PC,
    input  logic        UPDATE_TAKEN,
    input  logic [31:0] UPDATE_TARGET,
    input  logic        UPDATE_IS_JUMP
`ifdef BRANCH_TARGET_BUFFER_STATS_EN
    ,
    output logic [31:0] STAT_UPDATES,
    output logic [31:0] STAT_MISPREDICTS
`endif
);

    // Entry array. Only the valid bits are reset; the rest is qualified by valid.
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    // Byte-offset bits of both PCs carry no information for word-aligned fetch.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{PC_LOOKUP[1:0], UPDATE_PC[1:0]};

    // ------------------------------------------------------------------
    // Lookup
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;

    assign lk_idx = PC_LOOKUP[IDX_W+1:2];
    assign lk_tag = PC_LOOKUP[31:IDX_W+2];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    always_comb begin
        PREDICT_TAKEN  = lk_hit && ctr_q[lk_idx][1];
        PREDICT_TARGET = '0;
        if (PREDICT_TAKEN) begin
            PREDICT_TARGET = target_q[lk_idx];
        end
    end

    // ------------------------------------------------------------------
    // Update
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic [1:0]       up_ctr;
    logic [1:0]       up_ctr_step;
    logic             up_accept;
    logic             up_write;
    logic             up_write_target;
    logic [1:0]       up_ctr_new;

    assign up_idx = UPDATE_PC[IDX_W+1:2];
    assign up_tag = UPDATE_PC[31:IDX_W+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign up_ctr = ctr_q[up_idx];

    // Reset wins over a coincident resolution.
    assign up_accept = UPDATE_VALID && !RST;

    sat_counter_2bit u_sat_counter (
        .ctr_i          (up_ctr),
        .taken_i        (UPDATE_TAKEN),
        .force_strong_i (UPDATE_IS_JUMP),
        .ctr_o          (up_ctr_step)
    );

    always_comb begin
        up_write        = 1'b0;
        up_write_target = 1'b0;
        up_ctr_new      = up_ctr_step;
        if (UPDATE_IS_JUMP) begin
            // Jumps always (re)claim the entry as strongly taken.
            up_write        = 1'b1;
            up_write_target = 1'b1;
        end else if (up_hit) begin
            up_write        = 1'b1;
            up_write_target = UPDATE_TAKEN;
        end else if (UPDATE_TAKEN) begin
            // Allocate on a taken miss, evicting any alias at this index.
            up_write        = 1'b1;
            up_write_target = 1'b1;
            up_ctr_new      = WEAK_T;
        end
        // Not-taken misses are not worth an entry.
        up_write = up_write && up_accept;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
        end else if (up_write) begin
            valid_q[up_idx] <= 1'b1;
            tag_q[up_idx]   <= up_tag;
            ctr_q[up_idx]   <= up_ctr_new;
            if (up_write_target) begin
                target_q[up_idx] <= UPDATE_TARGET;
            end
        end
    end

`ifdef BRANCH_TARGET_BUFFER_STATS_EN
    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    logic        up_pred_taken;
    logic        up_mispredict;
    logic [31:0] stat_updates_q;
    logic [31:0] stat_mispredicts_q;

    // Prediction the table would have given for this PC before the update.
    assign up_pred_taken = up_hit && up_ctr[1];
    assign up_mispredict = (up_pred_taken != UPDATE_TAKEN) ||
                           (up_pred_taken && UPDATE_TAKEN &&
                            (target_q[up_idx] != UPDATE_TARGET));

    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_updates_q     <= '0;
            stat_mispredicts_q <= '0;
        end else if (up_accept) begin
            if (stat_updates_q != '1) begin
                stat_updates_q <= stat_updates_q + 32'd1;
            end
            if (up_mispredict && (stat_mispredicts_q != '1)) begin
                stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
            end
        end
    end

    assign STAT_UPDATES     = stat_updates_q;
    assign STAT_MISPREDICTS = stat_mispredicts_q;
`endif

endmodule
